// File: rtl/dmem_arbiter_if.sv
// Shared width package and the requester-side port bundle used by
// dmem_arbiter (one instance per master: CPU and debug/loader).
package types_pkg;
    localparam int DATA_WIDTH = 32;
endpackage

interface dmem_arbiter_if
    import types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DATA_WIDTH
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data RAM arbiter with read-modify-write for partial stores.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: CPU priority).
module dmem_arbiter
    import types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     cpu,
    dmem_arbiter_if.slave     dbg,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_wd,
    input  logic [DATA_W-1:0] ram_rd
);
    typedef enum logic {IDLE, RMW} state_t;

    state_t state, state_nxt;

    logic              cpu_pick;
    logic              dbg_sel;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [3:0]        win_be;
    logic [DATA_W-1:0] win_wdata;
    logic              start_rmw;

    logic [ADDR_W-1:0] rmw_addr;
    logic [3:0]        rmw_be;
    logic [DATA_W-1:0] rmw_wdata;
    logic [DATA_W-1:0] rmw_old;
    logic [DATA_W-1:0] merged;

    function automatic logic [DATA_W-1:0] word_addr(
        input logic [ADDR_W-1:0] a
    );
        logic [ADDR_W-1:0] t;
        t = {a[ADDR_W-1:2], 2'b00};
        return DATA_W'(t);
    endfunction

`ifdef DMEM_ARB_RR_EN
    logic last_dbg;

    assign cpu_pick = cpu.req & (~dbg.req | last_dbg);

    // Remember which port took the most recent grant.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last_dbg <= 1'b1;
        else if (cpu.gnt | dbg.gnt)
            last_dbg <= dbg.gnt;
    end
`else
    assign cpu_pick = cpu.req;
`endif

    assign dbg_sel = dbg.req & ~cpu_pick;

    // Route the winning requester's fields onto the shared path.
    always_comb begin
        if (dbg_sel) begin
            win_we    = dbg.we;
            win_addr  = dbg.addr;
            win_be    = dbg.be;
            win_wdata = dbg.wdata;
        end else begin
            win_we    = cpu.we;
            win_addr  = cpu.addr;
            win_be    = cpu.be;
            win_wdata = cpu.wdata;
        end
    end

    // Byte-lane merge of latched store data over the old word.
    always_comb begin
        merged = rmw_old;
        for (int i = 0; i < 4; i++) begin
            if (rmw_be[i])
                merged[8*i +: 8] = rmw_wdata[8*i +: 8];
        end
    end

    // Next-state, grants and RAM drive.
    always_comb begin
        state_nxt = state;
        cpu.gnt   = 1'b0;
        dbg.gnt   = 1'b0;
        ram_we    = 1'b0;
        ram_a     = word_addr(cpu.addr);
        ram_wd    = cpu.wdata;
        start_rmw = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n) begin
                    cpu.gnt = cpu_pick;
                    dbg.gnt = dbg_sel;
                    ram_a   = word_addr(win_addr);
                    ram_wd  = win_wdata;
                    if ((cpu_pick | dbg_sel) && win_we) begin
                        if (win_be == 4'b1111) begin
                            ram_we = 1'b1;
                        end else if (win_be != 4'b0000) begin
                            start_rmw = 1'b1;
                            state_nxt = RMW;
                        end
                    end
                end
            end
            RMW: begin
                ram_a     = word_addr(rmw_addr);
                ram_wd    = merged;
                ram_we    = rst_n;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture the partial store and the old word for the merge cycle.
    always_ff @(posedge clk) begin
        if (start_rmw) begin
            rmw_addr  <= win_addr;
            rmw_be    <= win_be;
            rmw_wdata <= win_wdata;
            rmw_old   <= ram_rd;
        end
    end

    // Registered load responses, one per port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu.rvalid <= 1'b0;
            cpu.rdata  <= '0;
            dbg.rvalid <= 1'b0;
            dbg.rdata  <= '0;
        end else begin
            cpu.rvalid <= cpu.gnt & ~cpu.we;
            dbg.rvalid <= dbg.gnt & ~dbg.we;
            if (cpu.gnt & ~cpu.we)
                cpu.rdata <= ram_rd;
            if (dbg.gnt & ~dbg.we)
                dbg.rdata <= ram_rd;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level memory model.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_we;
    logic [31:0] ram_a;
    logic [31:0] ram_wd;
    logic [31:0] ram_rd;
    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    dmem_arbiter_if cpu_if ();
    dmem_arbiter_if dbg_if ();

    dmem_arbiter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cpu    (cpu_if),
        .dbg    (dbg_if),
        .ram_we (ram_we),
        .ram_a  (ram_a),
        .ram_wd (ram_wd),
        .ram_rd (ram_rd)
    );

    always #5 clk = ~clk;

    assign ram_rd = mem[ram_a[11:2]];

    always @(posedge clk) begin
        if (ram_we)
            mem[ram_a[11:2]] <= ram_wd;
    end

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 4; i++)
            r = r | (((be[i] ? new_w : old_w) >> (8 * i)) & 32'hFF) << (8 * i);
        return r;
    endfunction

    task automatic idle_ports();
        cpu_if.req = 0; cpu_if.we = 0; cpu_if.addr = 0;
        cpu_if.be = 0; cpu_if.wdata = 0;
        dbg_if.req = 0; dbg_if.we = 0; dbg_if.addr = 0;
        dbg_if.be = 0; dbg_if.wdata = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_ports();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_reset();
        idle_ports();
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.be = 4'hF;
        cpu_if.addr = 32'h4000; cpu_if.wdata = 32'hCAFEF00D;
        dbg_if.req = 1;
        rst_n = 0;
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b0 || dbg_if.gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got %b%b expected 00",
                     cpu_if.gnt, dbg_if.gnt);
        end
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_we: got %b expected 0", ram_we);
        end
        checks++;
        if (cpu_if.rvalid !== 1'b0 || dbg_if.rvalid !== 1'b0 ||
            cpu_if.rdata !== 32'h0 || dbg_if.rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_resp: got %b %b %h %h expected 0 0 0 0",
                     cpu_if.rvalid, dbg_if.rvalid,
                     cpu_if.rdata, dbg_if.rdata);
        end
        idle_ports();
        next_cycle();
        rst_n = 1;
    endtask

    task automatic test_load();
        mem[0] = 32'hDEADBEEF;
        idle_ports();
        cpu_if.req = 1; cpu_if.addr = 32'h4000;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1 || ram_we !== 1'b0 || ram_a !== 32'h4000) begin
            errors++;
            $display("FAIL load_grant: got gnt=%b we=%b a=%h expected 1 0 4000",
                     cpu_if.gnt, ram_we, ram_a);
        end
        next_cycle();
        idle_ports();
        @(negedge clk);
        checks++;
        if (cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== 32'hDEADBEEF ||
            ram_we !== 1'b0) begin
            errors++;
            $display("FAIL load_data: got v=%b d=%h we=%b expected 1 deadbeef 0",
                     cpu_if.rvalid, cpu_if.rdata, ram_we);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (cpu_if.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL load_pulse: got %b expected 0", cpu_if.rvalid);
        end
        next_cycle();
    endtask

    task automatic test_full_store();
        idle_ports();
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.be = 4'hF;
        cpu_if.addr = 32'h4004; cpu_if.wdata = 32'h12345678;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1 || ram_we !== 1'b1 || ram_wd !== 32'h12345678) begin
            errors++;
            $display("FAIL full_store: got gnt=%b we=%b wd=%h expected 1 1 12345678",
                     cpu_if.gnt, ram_we, ram_wd);
        end
        next_cycle();
        idle_ports();
        cpu_if.req = 1; cpu_if.addr = 32'h4004;
        next_cycle();
        idle_ports();
        @(negedge clk);
        checks++;
        if (cpu_if.rvalid !== 1'b1 || cpu_if.rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL full_store_rb: got v=%b d=%h expected 1 12345678",
                     cpu_if.rvalid, cpu_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_partial_store();
        mem[2] = 32'h11223344;
        idle_ports();
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.be = 4'b0001;
        cpu_if.addr = 32'h4008; cpu_if.wdata = 32'h000000AB;
        dbg_if.req = 1; dbg_if.addr = 32'h4008;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1 || dbg_if.gnt !== 1'b0 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rmw_n: got c=%b d=%b we=%b expected 1 0 0",
                     cpu_if.gnt, dbg_if.gnt, ram_we);
        end
        next_cycle();
        cpu_if.req = 0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1 || ram_wd !== 32'h112233AB ||
            dbg_if.gnt !== 1'b0 || ram_a !== 32'h4008) begin
            errors++;
            $display("FAIL rmw_n1: got we=%b wd=%h a=%h dgnt=%b expected 1 112233ab 4008 0",
                     ram_we, ram_wd, ram_a, dbg_if.gnt);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (dbg_if.gnt !== 1'b1) begin
            errors++;
            $display("FAIL rmw_n2_gnt: got %b expected 1", dbg_if.gnt);
        end
        next_cycle();
        idle_ports();
        @(negedge clk);
        checks++;
        if (dbg_if.rvalid !== 1'b1 || dbg_if.rdata !== 32'h112233AB) begin
            errors++;
            $display("FAIL rmw_readback: got v=%b d=%h expected 1 112233ab",
                     dbg_if.rvalid, dbg_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_cpu;
`ifdef DMEM_ARB_RR_EN
        exp_cpu = 3'b101;
`else
        exp_cpu = 3'b111;
`endif
        do_reset();
        cpu_if.req = 1; cpu_if.addr = 32'h4000;
        dbg_if.req = 1; dbg_if.addr = 32'h4004;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (cpu_if.gnt !== exp_cpu[2-k] || dbg_if.gnt !== !exp_cpu[2-k]) begin
                errors++;
                $display("FAIL simul_%0d: got c=%b d=%b expected c=%b d=%b",
                         k, cpu_if.gnt, dbg_if.gnt,
                         exp_cpu[2-k], !exp_cpu[2-k]);
            end
            next_cycle();
        end
        idle_ports();
        next_cycle();
    endtask

    task automatic test_reset_mid_rmw();
        mem[3] = 32'hA5A5A5A5;
        idle_ports();
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.be = 4'b1100;
        cpu_if.addr = 32'h400C; cpu_if.wdata = 32'hBEEF0000;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw_grant: got gnt=%b we=%b expected 1 0",
                     cpu_if.gnt, ram_we);
        end
        next_cycle();
        idle_ports();
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rst_rmw_we: got %b expected 0", ram_we);
        end
        next_cycle();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || cpu_if.rvalid !== 1'b0 || dbg_if.rvalid !== 1'b0 ||
            cpu_if.rdata !== 32'h0 || dbg_if.rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_rmw_after: got we=%b v=%b%b d=%h %h expected all 0",
                     ram_we, cpu_if.rvalid, dbg_if.rvalid,
                     cpu_if.rdata, dbg_if.rdata);
        end
        cpu_if.req = 1; cpu_if.addr = 32'h400C;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_rmw_idle: got gnt=%b expected 1", cpu_if.gnt);
        end
        next_cycle();
        idle_ports();
        @(negedge clk);
        checks++;
        if (cpu_if.rdata !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL rst_rmw_word: got %h expected a5a5a5a5", cpu_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_zero_be();
        mem[4] = 32'h0BADF00D;
        idle_ports();
        cpu_if.req = 1; cpu_if.we = 1; cpu_if.be = 4'b0000;
        cpu_if.addr = 32'h4010; cpu_if.wdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++;
        if (cpu_if.gnt !== 1'b1 || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL zero_be_n: got gnt=%b we=%b expected 1 0",
                     cpu_if.gnt, ram_we);
        end
        next_cycle();
        cpu_if.we = 0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b0 || cpu_if.gnt !== 1'b1) begin
            errors++;
            $display("FAIL zero_be_n1: got we=%b gnt=%b expected 0 1",
                     ram_we, cpu_if.gnt);
        end
        next_cycle();
        idle_ports();
        @(negedge clk);
        checks++;
        if (cpu_if.rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL zero_be_word: got %h expected 0badf00d", cpu_if.rdata);
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] shadow [0:7];
        bit          c_out, d_out, pend, last_dbg;
        bit          exp_cv, exp_dv, ew_c, ew_d;
        logic [31:0] exp_cd, exp_dd, pend_val;
        int          pend_idx, idx;
        logic        w_we;
        logic [31:0] w_addr, w_wdata;
        logic [3:0]  w_be;
        int          sel;
        for (int i = 0; i < 8; i++) begin
            shadow[i] = $urandom;
            mem[i] = shadow[i];
        end
        do_reset();
        c_out = 0; d_out = 0; pend = 0; last_dbg = 1;
        exp_cv = 0; exp_dv = 0; exp_cd = 0; exp_dd = 0;
        pend_val = 0; pend_idx = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!c_out) begin
                cpu_if.req = 0;
                if ($urandom_range(0, 1) == 1) begin
                    c_out = 1;
                    cpu_if.req = 1;
                    cpu_if.we = $urandom_range(0, 1) == 1;
                    cpu_if.addr = 32'h4000 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
                    sel = $urandom_range(0, 3);
                    cpu_if.be = sel == 0 ? 4'hF : sel == 1 ? 4'h0 : 4'($urandom);
                    cpu_if.wdata = $urandom;
                end
            end
            if (!d_out) begin
                dbg_if.req = 0;
                if ($urandom_range(0, 1) == 1) begin
                    d_out = 1;
                    dbg_if.req = 1;
                    dbg_if.we = $urandom_range(0, 1) == 1;
                    dbg_if.addr = 32'h4000 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
                    sel = $urandom_range(0, 3);
                    dbg_if.be = sel == 0 ? 4'hF : sel == 1 ? 4'h0 : 4'($urandom);
                    dbg_if.wdata = $urandom;
                end
            end
            @(negedge clk);
            checks++;
            if (cpu_if.rvalid !== exp_cv || (exp_cv && cpu_if.rdata !== exp_cd)) begin
                errors++;
                $display("FAIL rnd_cpu_resp c%0d: got v=%b d=%h expected v=%b d=%h",
                         cyc, cpu_if.rvalid, cpu_if.rdata, exp_cv, exp_cd);
            end
            checks++;
            if (dbg_if.rvalid !== exp_dv || (exp_dv && dbg_if.rdata !== exp_dd)) begin
                errors++;
                $display("FAIL rnd_dbg_resp c%0d: got v=%b d=%h expected v=%b d=%h",
                         cyc, dbg_if.rvalid, dbg_if.rdata, exp_dv, exp_dd);
            end
            ew_c = 0; ew_d = 0;
            if (!pend) begin
                if (c_out && d_out) begin
`ifdef DMEM_ARB_RR_EN
                    ew_c = last_dbg;
                    ew_d = !last_dbg;
`else
                    ew_c = 1;
`endif
                end else begin
                    ew_c = c_out;
                    ew_d = d_out;
                end
            end
            checks++;
            if (cpu_if.gnt !== ew_c || dbg_if.gnt !== ew_d) begin
                errors++;
                $display("FAIL rnd_gnt c%0d: got c=%b d=%b expected c=%b d=%b",
                         cyc, cpu_if.gnt, dbg_if.gnt, ew_c, ew_d);
            end
            exp_cv = 0; exp_dv = 0;
            if (pend) begin
                checks++;
                if (ram_we !== 1'b1 || ram_wd !== pend_val ||
                    ram_a !== 32'h4000 + 4 * pend_idx) begin
                    errors++;
                    $display("FAIL rnd_rmw c%0d: got we=%b wd=%h a=%h expected 1 %h %h",
                             cyc, ram_we, ram_wd, ram_a, pend_val,
                             32'h4000 + 4 * pend_idx);
                end
                shadow[pend_idx] = pend_val;
                pend = 0;
            end else if (ew_c || ew_d) begin
                w_we = ew_d ? dbg_if.we : cpu_if.we;
                w_addr = ew_d ? dbg_if.addr : cpu_if.addr;
                w_be = ew_d ? dbg_if.be : cpu_if.be;
                w_wdata = ew_d ? dbg_if.wdata : cpu_if.wdata;
                idx = int'((w_addr - 32'h4000) / 4);
                checks++;
                if (ram_a !== 32'h4000 + 4 * idx) begin
                    errors++;
                    $display("FAIL rnd_addr c%0d: got %h expected %h",
                             cyc, ram_a, 32'h4000 + 4 * idx);
                end
                checks++;
                if (ram_we !== (w_we && w_be == 4'hF) ||
                    (w_we && w_be == 4'hF && ram_wd !== w_wdata)) begin
                    errors++;
                    $display("FAIL rnd_write c%0d: got we=%b wd=%h expected we=%b wd=%h",
                             cyc, ram_we, ram_wd, w_we && w_be == 4'hF, w_wdata);
                end
                if (!w_we) begin
                    if (ew_d) begin
                        exp_dv = 1; exp_dd = shadow[idx];
                    end else begin
                        exp_cv = 1; exp_cd = shadow[idx];
                    end
                end else if (w_be == 4'hF) begin
                    shadow[idx] = w_wdata;
                end else if (w_be != 4'h0) begin
                    pend = 1;
                    pend_idx = idx;
                    pend_val = merge_bytes(shadow[idx], w_wdata, w_be);
                end
                last_dbg = ew_d;
                if (ew_d) d_out = 0;
                else c_out = 0;
            end else begin
                checks++;
                if (ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_idle_we c%0d: got %b expected 0", cyc, ram_we);
                end
            end
            next_cycle();
        end
        idle_ports();
        next_cycle();
    endtask

    initial begin
        idle_ports();
        for (int i = 0; i < 1024; i++)
            mem[i] = 32'h0;
        test_reset();
        test_load();
        test_full_store();
        test_partial_store();
        test_simultaneous();
        test_reset_mid_rmw();
        test_zero_be();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
